// File: rtl/fir_tdm_engine_if.sv
// Purpose: bundles the sample, coefficient-port and result signals of fir_tdm_engine.
// Latency: none; wires only.
// Backpressure: none; the engine reports dropped samples on oOverrun instead of stalling.
interface fir_tdm_engine_if #(
  parameter int TAPS   = 40,
  parameter int DATA_W = 3,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16
);
  logic                         iEnSample_600k;
  logic signed [DATA_W-1:0]     iFirIn;
  logic                         iCsnRam;
  logic                         iWrnRam;
  logic [$clog2(TAPS)-1:0]      iAddrRam;
  logic signed [COEF_W-1:0]     iWrDtRam;
  logic                         iCoeffiUpdateFlag;
  logic [$clog2(TAPS+1)-1:0]    iNumOfCoeff;
  logic signed [OUT_W-1:0]      oFirOut;
  logic                         oFirValid;
  logic                         oBusy;
  logic                         oOverrun;

  modport master (
    output iEnSample_600k, iFirIn, iCsnRam, iWrnRam, iAddrRam, iWrDtRam,
           iCoeffiUpdateFlag, iNumOfCoeff,
    input  oFirOut, oFirValid, oBusy, oOverrun
  );

  modport slave (
    input  iEnSample_600k, iFirIn, iCsnRam, iWrnRam, iAddrRam, iWrDtRam,
           iCoeffiUpdateFlag, iNumOfCoeff,
    output oFirOut, oFirValid, oBusy, oOverrun
  );
endinterface

// File: rtl/fir_tdm_engine.sv
// Purpose: time-multiplexed FIR, LANES MAC lanes, double-buffered coefficients, round + saturate.
// Latency: strobe in cycle 0 -> oFirValid in cycle D+4, D = ceil(TAPS/LANES).
// Backpressure: none; a strobe while busy is dropped and flagged on oOverrun in that cycle.
module fir_tdm_engine #(
  parameter int TAPS   = 40,
  parameter int LANES  = 4,
  parameter int DATA_W = 3,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 32,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 16
) (
  input logic            iClk_12M,
  input logic            iRst,
  fir_tdm_engine_if.slave bus
);
  localparam int D  = (TAPS + LANES - 1) / LANES;
  localparam int AW = $clog2(TAPS);
  localparam int NW = $clog2(TAPS + 1);
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = DATA_W + COEF_W;
  // Half-LSB rounding constant; zero when no shift is applied.
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'((longint'(1) << SHIFT) >>> 1);
  localparam logic signed [ACC_W-1:0] OMAX = ACC_W'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OMIN = ACC_W'(-(longint'(1) << (OUT_W - 1)));

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_SUM, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      drain_q, drain_d;
  logic                      pend_q, pend_d;
  logic [NW-1:0]             ntap_q, ntap_d;
  logic signed [DATA_W-1:0]  x_q [TAPS];
  logic signed [DATA_W-1:0]  x_d [TAPS];
  logic signed [COEF_W-1:0]  shadow_q [TAPS];
  logic signed [COEF_W-1:0]  shadow_d [TAPS];
  logic signed [COEF_W-1:0]  active_q [TAPS];
  logic signed [COEF_W-1:0]  active_d [TAPS];
  logic                      rd_vld_q, rd_vld_d, mul_vld_q, mul_vld_d;
  logic signed [DATA_W-1:0]  rd_x_q [LANES];
  logic signed [DATA_W-1:0]  rd_x_d [LANES];
  logic signed [COEF_W-1:0]  rd_c_q [LANES];
  logic signed [COEF_W-1:0]  rd_c_d [LANES];
  logic signed [PW-1:0]      mul_q [LANES];
  logic signed [PW-1:0]      mul_d [LANES];
  logic signed [ACC_W-1:0]   acc_q [LANES];
  logic signed [ACC_W-1:0]   acc_d [LANES];
  logic signed [OUT_W-1:0]   out_q, out_d;
  logic                      vld_q, vld_d;
  logic signed [ACC_W-1:0]   sum_c, rnd_c, shr_c;
  logic                      accept;

  // Only a strobe seen in IDLE starts a computation.
  assign accept        = bus.iEnSample_600k && (state_q == S_IDLE);
  assign bus.oFirOut   = out_q;
  assign bus.oFirValid = vld_q;
  assign bus.oBusy     = (state_q != S_IDLE);
  assign bus.oOverrun  = bus.iEnSample_600k && (state_q != S_IDLE);

  // Sequencer: RUN walks D tap slots, DRAIN flushes the two-stage read/multiply pipe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
      S_RUN: if (cnt_q == CW'(D - 1)) begin
        state_d = S_DRAIN;
        drain_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      S_DRAIN: if (drain_q) state_d = S_SUM;
               else         drain_d = 1'b1;
      S_SUM:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shadow writes, swap-on-accept and delay-line shift. The swap copies the shadow
  // contents from before this cycle's write, so a coincident write stays in shadow.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    x_d      = x_q;
    ntap_d   = ntap_q;
    pend_d   = pend_q | bus.iCoeffiUpdateFlag;
    if (!bus.iCsnRam && !bus.iWrnRam && (int'(bus.iAddrRam) < TAPS))
      shadow_d[bus.iAddrRam] = bus.iWrDtRam;
    if (accept) begin
      x_d[0] = bus.iFirIn;
      for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
      if (pend_q || bus.iCoeffiUpdateFlag) begin
        active_d = shadow_q;
        ntap_d   = (int'(bus.iNumOfCoeff) > TAPS) ? NW'(TAPS) : bus.iNumOfCoeff;
        pend_d   = 1'b0;
      end
    end
  end

  // Per-lane read -> multiply -> accumulate; taps past N or TAPS read as zero.
  always_comb begin
    rd_vld_d  = (state_q == S_RUN);
    mul_vld_d = rd_vld_q;
    for (int l = 0; l < LANES; l++) begin
      int tap;
      tap       = l * D + int'(cnt_q);
      rd_c_d[l] = '0;
      rd_x_d[l] = '0;
      if (rd_vld_d && (tap < TAPS) && (tap < int'(ntap_q))) begin
        rd_c_d[l] = active_q[tap[AW-1:0]];
        rd_x_d[l] = x_q[tap[AW-1:0]];
      end
      mul_d[l] = PW'(rd_x_q[l]) * PW'(rd_c_q[l]);
      if (accept)         acc_d[l] = '0;
      else if (mul_vld_q) acc_d[l] = acc_q[l] + ACC_W'(mul_q[l]);
      else                acc_d[l] = acc_q[l];
    end
  end

  // Lane sum, round, shift and clamp; registered into the output in the SUM cycle.
  always_comb begin
    sum_c = '0;
    for (int l = 0; l < LANES; l++) sum_c = sum_c + acc_q[l];
    rnd_c = sum_c + RND;
    shr_c = rnd_c >>> SHIFT;
    out_d = out_q;
    vld_d = 1'b0;
    if (state_q == S_SUM) begin
      vld_d = 1'b1;
      if (shr_c > OMAX)      out_d = OMAX[OUT_W-1:0];
      else if (shr_c < OMIN) out_d = OMIN[OUT_W-1:0];
      else                   out_d = shr_c[OUT_W-1:0];
    end
  end

  // State register; reset aborts any computation and clears both banks.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      pend_q    <= 1'b0;
      ntap_q    <= '0;
      rd_vld_q  <= 1'b0;
      mul_vld_q <= 1'b0;
      out_q     <= '0;
      vld_q     <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]      <= '0;
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      for (int l = 0; l < LANES; l++) begin
        rd_x_q[l] <= '0;
        rd_c_q[l] <= '0;
        mul_q[l]  <= '0;
        acc_q[l]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      pend_q    <= pend_d;
      ntap_q    <= ntap_d;
      rd_vld_q  <= rd_vld_d;
      mul_vld_q <= mul_vld_d;
      out_q     <= out_d;
      vld_q     <= vld_d;
      x_q       <= x_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      rd_x_q    <= rd_x_d;
      rd_c_q    <= rd_c_d;
      mul_q     <= mul_d;
      acc_q     <= acc_d;
    end
  end
endmodule

// File: doc/fir_tdm_engine.md
Name: fir_tdm_engine

Overview:
- Parametrised, time-multiplexed direct-form FIR engine; successor to the fixed 33-tap, four-RAM filter top.
- Tap count, lane count and data, coefficient and output widths are generics.
- Coefficients are double-buffered: shadow and active banks, with a glitch-free swap at a sample boundary.
- Adds output-valid, busy and overrun flags, rounding and saturation. Sits between the sample source (600 kHz strobe) and the downstream output register, in the 12 MHz domain.

Parameters:
TAPS, 40, maximum tap count
LANES, 4, parallel MAC lanes; each lane serves taps l*D..l*D+D-1, D=ceil(TAPS/LANES)
DATA_W, 3, signed sample width
COEF_W, 16, signed coefficient width
ACC_W, 32, lane accumulator and final sum width
SHIFT, 0, arithmetic right shift applied to the final sum before saturation
OUT_W, 16, signed output width

Ports:
iClk_12M  in  1  clock
iRst  in  1  asynchronous reset, active-high
iEnSample_600k  in  1  one-cycle new-sample strobe
iFirIn  in  DATA_W  signed sample, valid with strobe
iCsnRam  in  1  coefficient chip select, active-low
iWrnRam  in  1  coefficient write enable, active-low
iAddrRam  in  clog2(TAPS)  flat tap index
iWrDtRam  in  COEF_W  signed coefficient
iCoeffiUpdateFlag  in  1  one-cycle request: shadow->active swap
iNumOfCoeff  in  clog2(TAPS+1)  requested tap count
oFirOut  out  OUT_W  signed filter result
oFirValid  out  1  one-cycle strobe, oFirOut updated
oBusy  out  1  computation in progress
oOverrun  out  1  one-cycle strobe, sample dropped

Behaviour:
- Reset (async, iRst=1): all outputs 0; delay line, both banks, accumulators, pending-swap flag and active tap count cleared; FSM to IDLE.
- Coefficient write: when iCsnRam=0 and iWrnRam=0, write shadow[iAddrRam]=iWrDtRam on the clock edge. Writes with iAddrRam>=TAPS are ignored. Writes never touch the active bank. Writes are allowed in any state.
- iCoeffiUpdateFlag sets a pending flag, which holds until consumed.
- Swap consumption: at an accepted sample strobe, if pending, copy shadow to active, latch N=min(iNumOfCoeff,TAPS) and clear pending. This happens before any tap of that sample is read.
- A flag arriving in the same cycle as an accepted strobe applies to that sample.
- Shadow writes in the same cycle as a swap: the write lands in shadow only.
- FSM IDLE -> RUN: on iEnSample_600k in IDLE. The delay line shifts: x[0]=iFirIn, x[k]=x[k-1]. Counter c=0.
- FSM RUN: lasts D cycles (c=0..D-1). Each lane l forms coef[l*D+c]*x[l*D+c], with product width DATA_W+COEF_W sign-extended to ACC_W, and accumulates it.
- Taps with index >=N or >=TAPS contribute 0.
- Lane accumulators clear at RUN entry.
- FSM RUN -> DRAIN: 2 cycles to flush the read/multiply pipeline.
- FSM DRAIN -> SUM: 1 cycle, sum of the lane accumulators (ACC_W, wrapping).
- FSM SUM -> DONE: 1 cycle.
  - SHIFT>0: add 2^(SHIFT-1), then arithmetic shift right by SHIFT.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Register oFirOut and pulse oFirValid.
  - Return to IDLE.
- Timing: strobe at cycle 0 -> oFirValid at cycle D+4 (14 for defaults). oBusy is high for cycles 1..D+4. oFirOut holds its value between results.
- Strobe while oBusy=1: the sample is discarded, the delay line is unchanged, and oOverrun pulses for that cycle. A pending swap stays pending.
- N=0: result is 0 and oFirValid still pulses.
- Reset asserted mid-computation: immediate abort, no oFirValid.

Test Plan:
- Reset: assert iRst during RUN -> oFirOut=0, oFirValid=0, oBusy=0 immediately; swap with no writes gives an all-zero response.
- Impulse:
  - Stimulus: write shadow[k]=k+1 for k=0..39, flag, N=40. Inputs 1,0,0,... one per 20 cycles.
  - Response: outputs 1,2,...,40, then 0. Each oFirValid arrives exactly 14 cycles after its strobe.
- Truncation: same coefficients, N=5, constant input 3 -> steady output 3*(1+2+3+4+5)=45. Output ramps 3,9,18,30,45.
- Saturation and rounding:
  - All coefficients 32767, input constant 3, N=40 -> output clamps to 32767.
  - Input -4 -> output clamps to -32768.
  - SHIFT=2, single coefficient 5, impulse 1 -> output 1 (5/4=1.25 rounds to 1); coefficient 6 -> 2.
- Double buffer:
  - Active bank holds coef0=1. Write shadow coef0=7 without flag -> impulse output 1.
  - Pulse flag -> next impulse output 7.
  - Flag coincident with the strobe -> that sample already uses 7.
- Overrun: second strobe 5 cycles after the first -> oOverrun pulses once, sample dropped; the following output matches a delay line without that sample.
